// File: rtl/spi_pkg.sv
// Shared definitions for the SPI controller: FSM state encoding, the fixed SPI mode and the
// byte width. Also provides a small constant helper used to size timers.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;

  // Mode 1: SCLK idles low, data is launched on the rising edge and captured on the falling one.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StLoad,
    StShift,
    StCsHold,
    StCsIdle
  } spi_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/spi_controller_shifter.sv
// Bit-level engine of the SPI controller. Serialises one byte per i_byte_start, MSB first,
// producing SCLK (idle low) and COPI, and deserialises CIPO.
//
// Ports:
//   i_clk, i_reset    system clock, synchronous active-high reset
//   i_byte_start      start shifting i_tx_byte (ignored while a byte is in flight)
//   i_tx_byte         byte to send
//   i_spi_cipo        peripheral data in, sampled on the i_clk edge that lowers SCLK
//   o_byte_done       combinational strobe in the last cycle of the 8th SCLK low half
//   o_spi_clk         SCLK
//   o_spi_copi        controller data out, updated on the i_clk edge that raises SCLK
//   o_rx_dv           one-cycle pulse after the 8th sample
//   o_rx_byte         received byte, held until the next o_rx_dv
module spi_controller_shifter
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_byte_start,
  input  logic [BYTE_W-1:0] i_tx_byte,
  input  logic              i_spi_cipo,
  output logic              o_byte_done,
  output logic              o_spi_clk,
  output logic              o_spi_copi,
  output logic              o_rx_dv,
  output logic [BYTE_W-1:0] o_rx_byte
);

  localparam int unsigned HALF_W = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(BYTE_W - 1);

  logic              active_q, active_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              copi_q, copi_d;
  logic [BYTE_W-1:0] tx_sr_q, tx_sr_d;
  logic [BYTE_W-1:0] rx_sr_q, rx_sr_d;
  logic              rx_dv_q, rx_dv_d;
  logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic              half_end;

  assign half_end    = active_q && (half_cnt_q == HALF_LAST);
  assign o_byte_done = half_end && !sclk_q && (bit_cnt_q == BIT_LAST);

  always_comb begin
    active_d   = active_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    copi_d     = copi_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_dv_d    = 1'b0;
    rx_byte_d  = rx_byte_q;

    if (i_byte_start && !active_q) begin
      // The accepting edge already raises SCLK and launches bit 7.
      active_d   = 1'b1;
      half_cnt_d = '0;
      bit_cnt_d  = '0;
      sclk_d     = 1'b1;
      copi_d     = i_tx_byte[BYTE_W-1];
      tx_sr_d    = {i_tx_byte[BYTE_W-2:0], 1'b0};
    end else if (active_q) begin
      if (!half_end) begin
        half_cnt_d = half_cnt_q + 1'b1;
      end else begin
        half_cnt_d = '0;
        if (sclk_q) begin
          sclk_d  = 1'b0;
          rx_sr_d = {rx_sr_q[BYTE_W-2:0], i_spi_cipo};
          if (bit_cnt_q == BIT_LAST) begin
            rx_dv_d   = 1'b1;
            rx_byte_d = {rx_sr_q[BYTE_W-2:0], i_spi_cipo};
          end
        end else if (bit_cnt_q == BIT_LAST) begin
          active_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          sclk_d    = 1'b1;
          copi_d    = tx_sr_q[BYTE_W-1];
          tx_sr_d   = {tx_sr_q[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active_q   <= 1'b0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= SPI_CPOL;
      copi_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      active_q   <= active_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_dv_q    <= rx_dv_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  assign o_spi_clk  = sclk_q;
  assign o_spi_copi = copi_q;
  assign o_rx_dv    = rx_dv_q;
  assign o_rx_byte  = rx_byte_q;

endmodule

// File: rtl/spi_controller.sv
// SPI controller (mode CPOL=0/CPHA=1). Runs one chip-select window per accepted i_start and
// moves i_num_bytes bytes through a byte-level valid/ready host interface.
//
// Ports:
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_start, i_num_bytes  start request and byte count (zero count is ignored)
//   o_busy                high from the cycle after start until CS idle time has elapsed
//   o_tx_ready, i_tx_dv,  TX byte handshake; transfer when both are high
//   i_tx_byte
//   o_rx_dv, o_rx_byte    received byte pulse and data
//   o_done                one-cycle pulse as CS_n returns high
//   o_spi_clk, o_spi_copi, i_spi_cipo, o_spi_cs_n   SPI pins
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned CNT_W             = 4,
  parameter int unsigned CS_SETUP_CLKS     = 2,
  parameter int unsigned CS_IDLE_CLKS      = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_bytes,
  output logic              o_busy,
  output logic              o_tx_ready,
  input  logic              i_tx_dv,
  input  logic [BYTE_W-1:0] i_tx_byte,
  output logic              o_rx_dv,
  output logic [BYTE_W-1:0] o_rx_byte,
  output logic              o_done,
  output logic              o_spi_clk,
  output logic              o_spi_copi,
  input  logic              i_spi_cipo,
  output logic              o_spi_cs_n
);

  localparam int unsigned TMR_MAX = max3(CS_SETUP_CLKS, CS_IDLE_CLKS, CLKS_PER_HALF_BIT);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP_CLKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(CS_IDLE_CLKS - 1);

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             byte_start;
  logic             byte_done;

  assign o_tx_ready = (state_q == StLoad);
  assign byte_start = o_tx_ready && i_tx_dv;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tmr_d       = tmr_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start && (i_num_bytes != '0)) begin
          state_d     = StCsSetup;
          cs_n_d      = 1'b0;
          busy_d      = 1'b1;
          remaining_d = i_num_bytes;
          tmr_d       = '0;
        end
      end
      StCsSetup: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = StLoad;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StLoad: begin
        // No timeout: CS stays asserted for as long as the host stalls.
        if (byte_start) state_d = StShift;
      end
      StShift: begin
        if (byte_done) begin
          remaining_d = remaining_q - 1'b1;
          tmr_d       = '0;
          state_d     = (remaining_q == CNT_W'(1)) ? StCsHold : StLoad;
        end
      end
      StCsHold: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = StCsIdle;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StCsIdle: begin
        if (tmr_q == IDLE_LAST) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      tmr_q       <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tmr_q       <= tmr_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  spi_controller_shifter #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_shifter (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_byte_start(byte_start),
    .i_tx_byte   (i_tx_byte),
    .i_spi_cipo  (i_spi_cipo),
    .o_byte_done (byte_done),
    .o_spi_clk   (o_spi_clk),
    .o_spi_copi  (o_spi_copi),
    .o_rx_dv     (o_rx_dv),
    .o_rx_byte   (o_rx_byte)
  );

  assign o_spi_cs_n = cs_n_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;

  localparam int unsigned CPH   = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SETUP = 2;
  localparam int unsigned IDLE  = 4;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_num_bytes = '0;
  logic             o_busy;
  logic             o_tx_ready;
  logic             i_tx_dv = 1'b0;
  logic [7:0]       i_tx_byte = '0;
  logic             o_rx_dv;
  logic [7:0]       o_rx_byte;
  logic             o_done;
  logic             o_spi_clk;
  logic             o_spi_copi;
  logic             i_spi_cipo = 1'b0;
  logic             o_spi_cs_n;

  spi_controller #(
    .CLKS_PER_HALF_BIT(CPH),
    .CNT_W            (CNT_W),
    .CS_SETUP_CLKS    (SETUP),
    .CS_IDLE_CLKS     (IDLE)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_num_bytes(i_num_bytes),
    .o_busy     (o_busy),
    .o_tx_ready (o_tx_ready),
    .i_tx_dv    (i_tx_dv),
    .i_tx_byte  (i_tx_byte),
    .o_rx_dv    (o_rx_dv),
    .o_rx_byte  (o_rx_byte),
    .o_done     (o_done),
    .o_spi_clk  (o_spi_clk),
    .o_spi_copi (o_spi_copi),
    .i_spi_cipo (i_spi_cipo),
    .o_spi_cs_n (o_spi_cs_n)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: bytes the controller should receive, bytes the peripheral should
  // receive, and bytes the peripheral model shifts out.
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_per_q[$];
  logic [7:0] per_tx_q[$];

  // Running event totals kept by the monitor; stimulus works with deltas.
  int rise_total = 0;
  int done_total = 0;
  int rxdv_total = 0;
  int rdy_rises = 0;
  int cs_low_cnt = 0;
  int cs_fall_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor + SPI peripheral model (drives CIPO after SCLK rise, samples COPI at SCLK fall).
  initial begin
    logic       sclk_prev = 1'b0;
    logic       cs_prev = 1'b1;
    logic       rdy_prev = 1'b0;
    logic [7:0] cur = '0;
    logic [7:0] per_rx = '0;
    int         rise_idx = 0;
    int         fall_idx = 0;
    forever begin
      @(negedge i_clk);
      if (o_spi_cs_n) begin
        rise_idx = 0;
        fall_idx = 0;
      end else begin
        cs_low_cnt++;
        if (cs_prev) cs_fall_total++;
        if (o_spi_clk && !sclk_prev) begin
          rise_total++;
          if (rise_idx == 0) cur = (per_tx_q.size() > 0) ? per_tx_q.pop_front() : 8'h00;
          i_spi_cipo = cur[7-rise_idx];
          rise_idx = (rise_idx + 1) % 8;
        end
        if (!o_spi_clk && sclk_prev) begin
          per_rx = {per_rx[6:0], o_spi_copi};
          fall_idx++;
          if (fall_idx == 8) begin
            fall_idx = 0;
            if (exp_per_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL per_rx_unexpected: got %02h expected none", per_rx);
            end else begin
              check("per_rx", {24'd0, per_rx}, {24'd0, exp_per_q.pop_front()});
            end
          end
        end
      end
      if (o_rx_dv) begin
        rxdv_total++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ctl_rx_unexpected: got %02h expected none", o_rx_byte);
        end else begin
          check("ctl_rx", {24'd0, o_rx_byte}, {24'd0, exp_rx_q.pop_front()});
        end
      end
      if (o_done) done_total++;
      if (o_tx_ready && !rdy_prev) rdy_rises++;
      rdy_prev  = o_tx_ready;
      sclk_prev = o_spi_clk;
      cs_prev   = o_spi_cs_n;
    end
  end

  task automatic run_txn(input int n, input logic [31:0] tx, input logic [31:0] per,
                         input int stall, input bit poke);
    int r0, d0, x0, y0, c0, f0, to;
    bit bad;
    r0 = rise_total; d0 = done_total; x0 = rxdv_total;
    y0 = rdy_rises;  c0 = cs_low_cnt; f0 = cs_fall_total;
    for (int i = 0; i < n; i++) begin
      per_tx_q.push_back(per[8*i +: 8]);
      exp_rx_q.push_back(per[8*i +: 8]);
      exp_per_q.push_back(tx[8*i +: 8]);
    end
    @(negedge i_clk);
    i_start = 1'b1;
    i_num_bytes = CNT_W'(n);
    @(negedge i_clk);
    i_start = 1'b0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      to = 0;
      while (!o_tx_ready && to < 200) begin
        @(negedge i_clk);
        to++;
      end
      check("tx_ready_seen", {31'd0, o_tx_ready}, 32'd1);
      if (i == 1 && stall > 0) begin
        bad = 1'b0;
        repeat (stall) begin
          @(negedge i_clk);
          if (o_spi_clk || o_spi_cs_n || !o_tx_ready) bad = 1'b1;
        end
        check("stall_quiet", {31'd0, bad}, 32'd0);
      end
      i_tx_dv = 1'b1;
      i_tx_byte = tx[8*i +: 8];
      @(negedge i_clk);
      i_tx_dv = 1'b0;
      if (poke && i == 0) begin
        i_start = 1'b1;
        i_num_bytes = CNT_W'(5);
        @(negedge i_clk);
        i_start = 1'b0;
      end
    end
    to = 0;
    while (done_total == d0 && to < 2000) begin
      @(negedge i_clk);
      to++;
    end
    to = 0;
    while (o_busy && to < 100) begin
      @(negedge i_clk);
      to++;
    end
    check("busy_released", {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge i_clk);
    check("sclk_rises", rise_total - r0, 8 * n);
    check("done_count", done_total - d0, 1);
    check("rx_dv_count", rxdv_total - x0, n);
    check("tx_ready_rises", rdy_rises - y0, n);
    check("cs_fall_count", cs_fall_total - f0, 1);
    check("cs_low_min", {31'd0, ((cs_low_cnt - c0) >= int'(SETUP + 32 * n + CPH))}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, x0, f0, to;
    bit bad;

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, o_spi_clk}, 32'd0);
    check("rst_copi", {31'd0, o_spi_copi}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_tx_ready", {31'd0, o_tx_ready}, 32'd0);
    check("rst_rx_dv", {31'd0, o_rx_dv}, 32'd0);
    check("rst_rx_byte", {24'd0, o_rx_byte}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Single byte: send A5, peripheral returns 3C
    run_txn(1, 32'h0000_00A5, 32'h0000_003C, 0, 1'b0);
    // Three bytes back to back
    run_txn(3, 32'h00FF_8001, 32'h0011_7EC4, 0, 1'b0);
    // Host stall of 50 cycles before byte 2
    run_txn(2, 32'h0000_D24B, 32'h0000_E718, 50, 1'b0);

    // Zero-length start is ignored
    d0 = done_total; f0 = cs_fall_total; bad = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_num_bytes = '0;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_busy || !o_spi_cs_n) bad = 1'b1;
    end
    check("zero_len_quiet", {31'd0, bad}, 32'd0);
    check("zero_len_no_cs", cs_fall_total - f0, 0);
    check("zero_len_no_done", done_total - d0, 0);

    // Start while busy is ignored: two bytes only
    run_txn(2, 32'h0000_3355, 32'h0000_AA0F, 0, 1'b1);

    // Reset during bit 4 of byte 1
    per_tx_q.push_back(8'h77);
    r0 = rise_total; d0 = done_total; x0 = rxdv_total;
    @(negedge i_clk);
    i_start = 1'b1;
    i_num_bytes = CNT_W'(2);
    @(negedge i_clk);
    i_start = 1'b0;
    to = 0;
    while (!o_tx_ready && to < 200) begin
      @(negedge i_clk);
      to++;
    end
    i_tx_dv = 1'b1;
    i_tx_byte = 8'hF0;
    @(negedge i_clk);
    i_tx_dv = 1'b0;
    to = 0;
    while ((rise_total - r0) < 4 && to < 200) begin
      @(negedge i_clk);
      to++;
    end
    check("reset_reached_bit4", rise_total - r0, 4);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    check("abort_cs_n", {31'd0, o_spi_cs_n}, 32'd1);
    check("abort_sclk", {31'd0, o_spi_clk}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_tx_ready", {31'd0, o_tx_ready}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);
    check("abort_no_rx_dv", rxdv_total - x0, 0);
    check("abort_no_done", done_total - d0, 0);
    run_txn(1, 32'h0000_0096, 32'h0000_0069, 0, 1'b0);

    // Peripheral loaded with 5A, controller sends C3
    run_txn(1, 32'h0000_00C3, 32'h0000_005A, 0, 1'b0);

    repeat (5) @(negedge i_clk);
    check("exp_rx_drained", exp_rx_q.size(), 0);
    check("exp_per_drained", exp_per_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- Single-clock SPI controller that sequences multi-byte SPI transactions towards SPIPeripheral-compatible devices.
- Generates SCLK, chip select and COPI, and deserialises CIPO.
- Host side uses a byte-level valid/ready handshake.
- Sits between a host FSM/CPU bridge and an off-chip or on-board SPI peripheral, one transaction (CS low window) per i_start.

Parameters:
- CLKS_PER_HALF_BIT, 2, i_clk cycles per SCLK half period; min 2; default gives SCLK = i_clk/4.
- CNT_W, 4, width of byte-count field; max transaction length 2^CNT_W-1 bytes.
- CS_SETUP_CLKS, 2, i_clk cycles between CS_n falling and first SCLK rising edge; min 1.
- CS_IDLE_CLKS, 4, minimum i_clk cycles CS_n held high after a transaction before a new i_start is accepted; min 1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  start a transaction; sampled only when o_busy=0.
- i_num_bytes  in  CNT_W  byte count, captured with i_start.
- o_busy  out  1  high from the cycle after accepted i_start until CS idle time has elapsed.
- o_tx_ready  out  1  controller can accept next TX byte.
- i_tx_dv  in  1  TX byte valid; transfer occurs when i_tx_dv and o_tx_ready are both high.
- i_tx_byte  in  8  byte to send, MSB first.
- o_rx_dv  out  1  one-cycle pulse, received byte valid.
- o_rx_byte  out  8  received byte; held until next o_rx_dv.
- o_done  out  1  one-cycle pulse when CS_n returns high after the last byte.
- o_spi_clk  out  1  SCLK, idle low.
- o_spi_copi  out  1  controller data out.
- i_spi_cipo  in  1  peripheral data in.
- o_spi_cs_n  out  1  chip select, active low.

Behaviour:
- Outputs are registered except o_tx_ready, which is state-decoded.
- Reset values: o_spi_cs_n=1, o_spi_clk=0, o_spi_copi=0, o_busy=0, o_tx_ready=0, o_rx_dv=0, o_rx_byte=0, o_done=0, state IDLE.
- Reset mid-transaction: all of the above apply at the next edge. No partial o_rx_dv, no o_done.
- SPI mode is fixed at CPOL=0, CPHA=1 to match the peripheral (which drives CIPO on SCLK rise and samples COPI on SCLK fall).
- COPI changes on the same i_clk edge that raises SCLK. CIPO is sampled on the i_clk edge that lowers SCLK.
- FSM states:
  - IDLE: i_start with i_num_bytes!=0 → CS_SETUP. Next cycle: o_spi_cs_n=0, o_busy=1, remaining=i_num_bytes. i_start with i_num_bytes==0 is ignored (no CS activity, no o_done).
  - CS_SETUP: count CS_SETUP_CLKS cycles → LOAD.
  - LOAD: o_tx_ready=1 and SCLK held low. On i_tx_dv → SHIFT, latch i_tx_byte; next edge raises SCLK and drives bit 7. No timeout: CS stays low indefinitely while waiting.
  - SHIFT: 8 bits, each SCLK high CLKS_PER_HALF_BIT cycles then low CLKS_PER_HALF_BIT cycles. The edge performing the 8th sample sets o_rx_dv=1 and o_rx_byte=shift register, so both are visible the next cycle. remaining decrements at the end of the 8th low half. remaining>0 → LOAD; otherwise → CS_HOLD.
  - CS_HOLD: one CLKS_PER_HALF_BIT period with SCLK low, then o_spi_cs_n=1 and o_done pulse → CS_IDLE.
  - CS_IDLE: count CS_IDLE_CLKS → IDLE, o_busy=0.
- i_start while o_busy=1 is ignored. i_tx_dv outside LOAD is ignored.
- Bit counter 3 bits, wraps 0→7 per byte. Half-period counter width is $clog2(CLKS_PER_HALF_BIT).
- SCLK edge count per transaction is exactly 8*N rising and 8*N falling.

Decomposition:
- Package spi_pkg: FSM state encoding, SPI_MODE constants (CPOL=0, CPHA=1), BYTE_W=8.
- Sub-module spi_controller_shifter: half-period timer, SCLK toggling, 8-bit TX/RX shift registers, byte_start/byte_done strobes.
- spi_controller keeps the FSM, byte count, CS timing and host handshake.

Test Plan:
- 1-byte transfer, CLKS_PER_HALF_BIT=2: tx 8'hA5, loopback model returns 8'h3C → COPI shows 1,0,1,0,0,1,0,1 on SCLK rises; o_rx_byte=8'h3C with one o_rx_dv; o_done once; 8 SCLK pulses; CS_n low 2+32+2 cycles minimum.
- 3-byte transfer, tx 8'h01/8'h80/8'hFF presented immediately: 3 o_rx_dv pulses; CS_n stays low throughout; 24 SCLK rises; o_tx_ready high once per byte.
- Host stall: hold i_tx_dv low for 50 cycles before byte 2 → SCLK low and CS_n low for the whole stall; byte 2 data correct.
- i_num_bytes=0 with i_start → no CS_n change, o_busy stays 0, no o_done. Also: i_start during o_busy → ignored, byte count unchanged.
- i_reset asserted during bit 4 of byte 1 → next cycle CS_n=1, SCLK=0, o_busy=0; no o_rx_dv; a new transaction afterwards completes correctly.
- Against the SPIPeripheral model with 4x clock: peripheral loaded with 8'h5A, controller sends 8'hC3 → controller o_rx_byte=8'h5A, peripheral o_rx_byte=8'hC3.
